// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the debounced-input conditioner: nibble width,
// default qualification length and reset value, FSM state encoding and
// the packed nibble payload that drives {a,b,c,d}.
package input_debouncer_pkg;

  localparam int unsigned NIBBLE_W = 4;

  // Defaults reused by any debounced input built on this block.
  localparam int unsigned          DEF_STABLE_CYCLES = 4;
  localparam logic [NIBBLE_W-1:0]  DEF_RESET_VAL     = 4'b0000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CHECK = 1'b1
  } state_e;

  // Bit order matches the raw nibble: bit3 -> a ... bit0 -> d.
  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } nibble_t;

  // Counter width able to hold 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/input_debouncer_sync2.sv
// Two-flop synchroniser, one pair of flops per bit.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   d_i        : asynchronous input bus
//   q_o        : synchronised bus (second stage)
module input_debouncer_sync2 #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Both stages load the reset value so no spurious edge leaves reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Four-bit input conditioner: synchronises a bouncing nibble and accepts a
// new value only after it has been seen unchanged for STABLE_CYCLES clocks.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   raw[3:0]       : unsynchronised nibble (bit3 -> a ... bit0 -> d)
//   a, b, c, d     : debounced stable nibble (registered)
//   changed        : one-cycle strobe coincident with a new {a,b,c,d}
//   busy           : candidate under qualification (decoded from state)
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned         STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic [NIBBLE_W-1:0] RESET_VAL     = DEF_RESET_VAL
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NIBBLE_W-1:0] raw,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                changed,
  output logic                busy
);

  localparam int unsigned      CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_param
    $error("input_debouncer: STABLE_CYCLES must be in 2..255");
  end

  logic [NIBBLE_W-1:0] sync;
  state_e              state_q,   state_d;
  nibble_t             stable_q,  stable_d;
  logic [NIBBLE_W-1:0] cand_q,    cand_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                changed_q, changed_d;

  input_debouncer_sync2 #(
    .WIDTH     (NIBBLE_W),
    .RESET_VAL (RESET_VAL)
  ) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (raw),
    .q_o   (sync)
  );

  // State, candidate, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stable_q  <= nibble_t'(RESET_VAL);
      cand_q    <= RESET_VAL;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  // Next-state logic; CHECK conditions are evaluated in priority order.
  always_comb begin
    state_d   = state_q;
    stable_d  = stable_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync != NIBBLE_W'(stable_q)) begin
          cand_d  = sync;
          cnt_d   = CNT_ONE;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sync == NIBBLE_W'(stable_q)) begin
          // Input bounced back to the accepted value.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sync != cand_q) begin
          // Different non-stable value: restart qualification on it.
          cand_d = sync;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = nibble_t'(cand_q);
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign a       = stable_q.a;
  assign b       = stable_q.b;
  assign c       = stable_q.c;
  assign d       = stable_q.d;
  assign changed = changed_q;
  assign busy    = (state_q == ST_CHECK);

endmodule

// File: tb/tb_input_debouncer.sv
module tb_input_debouncer;

  localparam int unsigned S  = 4;
  localparam logic [3:0]  RV = 4'b0000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] raw   = 4'b1010;
  logic       a, b, c, d, changed, busy;

  int errors = 0;
  int checks = 0;

  input_debouncer #(.STABLE_CYCLES(S), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .changed (changed),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two-stage delay line feeds a history of FSM-visible samples. A value is
  // accepted when it differs from the stable value and has been seen in
  // exactly S consecutive samples; busy means the latest sample differs from
  // the (updated) stable value.
  logic [3:0] m_s1, m_s2, m_smp, m_stable;
  logic       m_changed, m_busy;
  logic [3:0] hist[$];

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = RV; m_s2 = RV; m_stable = RV;
      m_changed = 1'b0; m_busy = 1'b0;
      hist.delete();
    end else begin
      m_smp = m_s2;
      m_s2  = m_s1;
      m_s1  = raw;
      hist.push_back(m_smp);
      if (hist.size() > S + 1) void'(hist.pop_front());
      m_changed = 1'b0;
      if (m_smp != m_stable && run_len() == int'(S)) begin
        m_stable  = m_smp;
        m_changed = 1'b1;
      end
      m_busy = (m_smp != m_stable);
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_abcd",    {4'b0, a, b, c, d}, {4'b0, m_stable});
    chk("model_changed", {7'b0, changed},    {7'b0, m_changed});
    chk("model_busy",    {7'b0, busy},       {7'b0, m_busy});
  end

  // ---------------- directed + random stimulus ----------------
  task automatic apply(input logic [3:0] v);
    @(negedge clk);
    raw = v;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_busy, n_chg;
    logic [3:0] prev, v;
    bit found;

    // Reset with raw = 1010: everything held at reset values.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk("reset_outputs", {2'b0, a, b, c, d, changed, busy}, 8'h00);
    end
    apply(4'b0000);
    rst_n = 1'b1;
    repeat (4) edge1();

    // Clean step 0000 -> 1011.
    apply(4'b1011);
    n_busy = 0; n_chg = 0;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      n_busy += int'(busy);
      n_chg  += int'(changed);
      if (e == 5) chk("step_before", {4'b0, a, b, c, d}, 8'h00);
      if (e == 6) begin
        chk("step_abcd",    {4'b0, a, b, c, d}, 8'h0B);
        chk("step_changed", {7'b0, changed},   8'h01);
      end
      if (e == 7) chk("step_pulse_end", {7'b0, changed}, 8'h00);
    end
    chk("step_busy_cycles", 8'(n_busy), 8'd3);
    chk("step_pulses",      8'(n_chg),  8'd1);

    // Return to 0000, then a 2-cycle glitch must be filtered.
    apply(4'b0000);
    repeat (10) edge1();
    apply(4'b0100);
    repeat (2) edge1();
    apply(4'b0000);
    n_chg = 0;
    for (int e = 0; e < 10; e++) begin
      edge1();
      n_chg += int'(changed);
    end
    chk("glitch_abcd",   {4'b0, a, b, c, d}, 8'h00);
    chk("glitch_pulses", 8'(n_chg), 8'd0);

    // Bounce 0001 (2 cycles) then 0011 held.
    apply(4'b0001);
    repeat (2) edge1();
    apply(4'b0011);
    n_chg = 0; found = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      edge1();
      n_chg += int'(changed);
      if ({a, b, c, d} == 4'b0001) found = 1'b1;
      if (e == 5) chk("bounce_before", {4'b0, a, b, c, d}, 8'h00);
      if (e == 6) chk("bounce_abcd",   {4'b0, a, b, c, d}, 8'h03);
    end
    chk("bounce_pulses",   8'(n_chg), 8'd1);
    chk("bounce_never_01", {7'b0, found}, 8'h00);

    // Reset mid-CHECK.
    apply(4'b0000);
    repeat (10) edge1();
    apply(4'b0110);
    found = 1'b0;
    for (int e = 0; e < 10 && !found; e++) begin
      edge1();
      if (busy) found = 1'b1;
    end
    chk("midreset_busy_rose", {7'b0, found}, 8'h01);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("midreset_async", {2'b0, a, b, c, d, changed, busy}, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      edge1();
      if (e == 5) chk("midreset_before", {4'b0, a, b, c, d}, 8'h00);
      if (e == 6) begin
        chk("midreset_abcd",    {4'b0, a, b, c, d}, 8'h06);
        chk("midreset_changed", {7'b0, changed},   8'h01);
      end
    end
    repeat (4) edge1();

    // Random regression: nibbles held 10 cycles.
    prev = 4'b0110;
    for (int k = 0; k < 100; k++) begin
      v = 4'($urandom_range(0, 15));
      apply(v);
      n_chg = 0;
      for (int e = 1; e <= 10; e++) begin
        edge1();
        n_chg += int'(changed);
        if (e == 5) chk("rand_before", {4'b0, a, b, c, d}, {4'b0, prev});
        if (e == 6) chk("rand_abcd",   {4'b0, a, b, c, d}, {4'b0, v});
      end
      chk("rand_pulses", 8'(n_chg), (v != prev) ? 8'd1 : 8'd0);
      prev = v;
    end

    repeat (3) edge1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
